jt51_noise_ctrl: RTL and testbench
==================================

JT51_NOISE_CTRL -- requirements
Module: jt51_noise_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock; all state changes on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port cen, input, 1 bit: phi-1 clock enable; no state changes when low, including the state machine and counters.
REQ-004 SHALL have port wr_n, input, 1 bit: register write strobe, active-low, sampled on cen.
REQ-005 SHALL have port addr, input, 8 bits: register address qualifying wr_n.
REQ-006 SHALL have port din, input, 8 bits: register data; bit 7 = NE, bits 4:0 = NFRQ.
REQ-007 SHALL have port eg_in, input, 10 bits: slot-31 envelope attenuation from the envelope generator.
REQ-008 SHALL have port cycles, output, 5 bits: slot counter driving the noise generator.
REQ-009 SHALL have port nfrq, output, 5 bits: applied noise frequency.
REQ-010 SHALL have port ne, output, 1 bit: applied noise enable.
REQ-011 SHALL have port op31_no, output, 1 bit: noise mix strobe, high during slot 31.
REQ-012 SHALL have port noise_eg, output, 10 bits: envelope supplied to the noise mixer.
REQ-013 SHALL have port busy, output, 1 bit: high while a write is pending.

Function
REQ-014 SHALL increment cycles by 1 on every cen, wrapping from 31 to 0.
REQ-015 SHALL drive op31_no combinationally as (cycles == 31).
REQ-016 SHALL treat a write as a cen cycle with wr_n = 0 and addr = 8'h0F; all other addresses are ignored.
REQ-017 SHALL use a two-state FSM:
- IDLE -> PEND on a write; din is captured into the pending register.
- PEND -> IDLE at the frame boundary (cen with cycles == 31); the pending value is copied to ne/nfrq.
- Applied values become visible in the same edge that wraps cycles to 0.
REQ-018 SHALL, on a write while in PEND, overwrite the pending value (last write wins) and stay in PEND.
REQ-019 SHALL, on a write coinciding with the frame boundary, apply the new din directly to ne/nfrq and end in IDLE; the older pending value is discarded.
REQ-020 SHALL drive busy = 1 exactly while in PEND.
REQ-021 SHALL, on cen with cycles == 31, load noise_eg with eg_in if the applied ne = 1, else with 10'h3FF (silent); noise_eg holds otherwise.
REQ-022 SHALL keep nfrq and ne stable throughout a frame (slots 0..31).

Reset
REQ-023 SHALL, on rst, set:
- cycles = 0, nfrq = 0, ne = 0
- noise_eg = 10'h3FF, busy = 0
- FSM = IDLE, pending register = 0
REQ-024 SHALL, on rst asserted mid-PEND, discard the pending write.
REQ-025 SHALL give rst priority over cen and writes.

Configuration
REQ-026 SHALL support the macro JT51_NOISE_SYNC_EN.
- Defined: frame-boundary application per REQ-017..019.
- Undefined: a write updates ne/nfrq on the same cen edge, the FSM stays in IDLE, and busy is tied to 0.

Structure
REQ-027 SHALL place the following in package jt51_noise_ctrl_pkg:
- NOISE_REG_ADDR = 8'h0F
- EG_SILENT = 10'h3FF
- CYCLE_LAST = 5'd31
- FSM state typedef (IDLE, PEND)
REQ-028 SHALL be a single module with no sub-modules; it instantiates no noise generator, and the integrator connects its outputs to jt51_noise.

Verification
REQ-029 SHALL cover, with JT51_NOISE_SYNC_EN defined: write 8'h9F at cycles = 5 -> busy = 1 through cycles = 31; ne = 1 and nfrq = 31 appear with cycles = 0; busy = 0 afterwards.
REQ-030 SHALL cover: writes 8'h81 then 8'h83 in one frame -> nfrq = 3 applied at wrap; value 1 is never visible.
REQ-031 SHALL cover: write 8'h85 exactly at cycles = 31 with an older 8'h82 pending -> nfrq = 5, ne = 1 next edge; busy = 0.
REQ-032 SHALL cover: ne = 1, eg_in = 10'h155 at slot 31 -> noise_eg = 10'h155; then ne = 0 -> noise_eg = 10'h3FF at the next slot 31.
REQ-033 SHALL cover: rst during PEND at cycles = 12 -> all outputs at reset values next edge; the pending write is never applied.
REQ-034 SHALL cover: cen held low for 10 clocks -> cycles, FSM and noise_eg unchanged; with the macro undefined, a write updates nfrq on the same edge.

Source files
------------

// File: rtl/jt51_noise_ctrl_pkg.sv
// Shared constants and FSM state type for the JT51 noise control block.
// Imported by jt51_noise_ctrl.
package jt51_noise_ctrl_pkg;

    localparam logic [7:0] NOISE_REG_ADDR = 8'h0F;
    localparam logic [9:0] EG_SILENT      = 10'h3FF;
    localparam logic [4:0] CYCLE_LAST     = 5'd31;

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } state_t;

endpackage

// File: rtl/jt51_noise_ctrl.sv
// Noise register/slot control for jt51_noise: slot counter, NE/NFRQ application, slot-31 envelope latch.
// Optional JT51_NOISE_SYNC_EN defers register writes to the frame boundary (busy while pending).
module jt51_noise_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       cen,
    input  logic       wr_n,
    input  logic [7:0] addr,
    input  logic [7:0] din,
    input  logic [9:0] eg_in,
    output logic [4:0] cycles,
    output logic [4:0] nfrq,
    output logic       ne,
    output logic       op31_no,
    output logic [9:0] noise_eg,
    output logic       busy
);
    import jt51_noise_ctrl_pkg::*;

    logic wr_hit;
    logic frame_end;
    logic unused_din;

    assign wr_hit     = cen & ~wr_n & (addr == NOISE_REG_ADDR);
    assign frame_end  = (cycles == CYCLE_LAST);
    assign op31_no    = frame_end;
    assign unused_din = ^din[6:5];

    // The envelope latch uses the ne value in force during slot 31, before any same-edge update.
    always_ff @(posedge clk) begin
        if (rst) begin
            cycles   <= 5'd0;
            noise_eg <= EG_SILENT;
        end else if (cen) begin
            cycles <= cycles + 5'd1;
            if (frame_end)
                noise_eg <= ne ? eg_in : EG_SILENT;
        end
    end

`ifdef JT51_NOISE_SYNC_EN
    state_t     state;
    logic [5:0] pend;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            pend  <= 6'd0;
            ne    <= 1'b0;
            nfrq  <= 5'd0;
        end else if (cen) begin
            if (frame_end) begin
                // A write landing on the boundary supersedes whatever was pending.
                if (wr_hit)
                    {ne, nfrq} <= {din[7], din[4:0]};
                else if (state == PEND)
                    {ne, nfrq} <= pend;
                state <= IDLE;
                busy  <= 1'b0;
            end else if (wr_hit) begin
                pend  <= {din[7], din[4:0]};
                state <= PEND;
                busy  <= 1'b1;
            end
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            ne   <= 1'b0;
            nfrq <= 5'd0;
        end else if (wr_hit) begin
            {ne, nfrq} <= {din[7], din[4:0]};
        end
    end

    assign busy = 1'b0;
`endif

endmodule

// File: tb/tb_jt51_noise_ctrl.sv
// Self-checking bench for jt51_noise_ctrl against a frame-level reference model.
// Works with or without JT51_NOISE_SYNC_EN defined.
module tb_jt51_noise_ctrl;

`ifdef JT51_NOISE_SYNC_EN
    localparam bit SYNC = 1'b1;
`else
    localparam bit SYNC = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst, cen, wr_n;
    logic [7:0] addr, din;
    logic [9:0] eg_in;
    logic [4:0] cycles, nfrq;
    logic       ne, op31_no, busy;
    logic [9:0] noise_eg;

    int checks = 0;
    int errors = 0;

    // Reference model: slot number, applied register, optional pending write.
    int         m_slot;
    logic       m_ne;
    logic [4:0] m_nfrq;
    bit         m_pv;
    logic [7:0] m_pval;
    logic [9:0] m_eg;

    jt51_noise_ctrl dut (
        .clk(clk), .rst(rst), .cen(cen), .wr_n(wr_n), .addr(addr), .din(din),
        .eg_in(eg_in), .cycles(cycles), .nfrq(nfrq), .ne(ne), .op31_no(op31_no),
        .noise_eg(noise_eg), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    function automatic void model_step(input logic c, input logic w, input logic [7:0] a,
                                       input logic [7:0] d, input logic [9:0] e, input logic r);
        bit is_wr;
        bit boundary;
        is_wr    = c && !w && (a == 8'h0F);
        boundary = (m_slot == 31);
        if (r) begin
            m_slot = 0; m_ne = 1'b0; m_nfrq = 5'd0;
            m_pv = 1'b0; m_pval = 8'h00; m_eg = 10'h3FF;
        end else if (c) begin
            if (boundary)
                m_eg = m_ne ? e : 10'h3FF;
            if (SYNC) begin
                if (boundary) begin
                    if (is_wr) begin
                        m_ne = d[7]; m_nfrq = d[4:0];
                    end else if (m_pv) begin
                        m_ne = m_pval[7]; m_nfrq = m_pval[4:0];
                    end
                    m_pv = 1'b0;
                end else if (is_wr) begin
                    m_pval = d; m_pv = 1'b1;
                end
            end else if (is_wr) begin
                m_ne = d[7]; m_nfrq = d[4:0];
            end
            m_slot = (m_slot + 1) % 32;
        end
    endfunction

    function automatic logic [22:0] dut_vec();
        return {cycles, nfrq, ne, op31_no, noise_eg, busy};
    endfunction

    function automatic logic [22:0] mdl_vec();
        return {5'(m_slot), m_nfrq, m_ne, (m_slot == 31), m_eg, (SYNC && m_pv)};
    endfunction

    task automatic tick(input logic c, input logic w, input logic [7:0] a,
                        input logic [7:0] d, input logic [9:0] e, input logic r);
        rst = r; cen = c; wr_n = w; addr = a; din = d; eg_in = e;
        @(posedge clk);
        model_step(c, w, a, d, e, r);
        @(negedge clk);
    endtask

    task automatic idle_tick(input logic [9:0] e);
        tick(1'b1, 1'b1, 8'h00, 8'($urandom), e, 1'b0);
    endtask

    task automatic adv_to(input int s, input logic [9:0] e);
        for (int n = 0; n < 40 && m_slot != s; n++)
            idle_tick(e);
    endtask

    task automatic wr(input logic [7:0] d, input logic [9:0] e);
        tick(1'b1, 1'b0, 8'h0F, d, e, 1'b0);
    endtask

    task automatic test_reset();
        tick(1'b1, 1'b0, 8'h0F, 8'hFF, 10'h0AA, 1'b1);
        tick(1'b1, 1'b0, 8'h0F, 8'hFF, 10'h0AA, 1'b1);
        checks++; if (cycles !== 5'd0)        begin errors++; $display("FAIL reset_cycles: got %0d want 0", cycles); end
        checks++; if (nfrq !== 5'd0)          begin errors++; $display("FAIL reset_nfrq: got %0d want 0", nfrq); end
        checks++; if (ne !== 1'b0)            begin errors++; $display("FAIL reset_ne: got %b want 0", ne); end
        checks++; if (noise_eg !== 10'h3FF)   begin errors++; $display("FAIL reset_noise_eg: got %h want 3ff", noise_eg); end
        checks++; if (busy !== 1'b0)          begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (op31_no !== 1'b0)       begin errors++; $display("FAIL reset_op31: got %b want 0", op31_no); end
    endtask

    task automatic test_deferred_write();
        adv_to(5, 10'h100);
        wr(8'h9F, 10'h100);
        for (int n = 0; n < 40 && m_slot != 0; n++) begin
            checks++;
            if (busy !== SYNC) begin errors++; $display("FAIL deferred_busy slot %0d: got %b want %b", m_slot, busy, SYNC); end
            checks++;
            if (dut_vec() !== mdl_vec()) begin errors++; $display("FAIL deferred_vec: got %h want %h", dut_vec(), mdl_vec()); end
            idle_tick(10'h100);
        end
        checks++; if (cycles !== 5'd0)  begin errors++; $display("FAIL deferred_wrap_cycles: got %0d want 0", cycles); end
        checks++; if (ne !== 1'b1)      begin errors++; $display("FAIL deferred_ne: got %b want 1", ne); end
        checks++; if (nfrq !== 5'd31)   begin errors++; $display("FAIL deferred_nfrq: got %0d want 31", nfrq); end
        checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL deferred_busy_after: got %b want 0", busy); end
    endtask

    task automatic test_last_write_wins();
        adv_to(3, 10'h0F0);
        wr(8'h81, 10'h0F0);
        adv_to(10, 10'h0F0);
        wr(8'h83, 10'h0F0);
        for (int n = 0; n < 40 && m_slot != 0; n++) begin
            if (SYNC) begin
                checks++;
                if (nfrq === 5'd1) begin errors++; $display("FAIL lww_intermediate_visible slot %0d: got nfrq 1 want not 1", m_slot); end
            end
            checks++;
            if (dut_vec() !== mdl_vec()) begin errors++; $display("FAIL lww_vec: got %h want %h", dut_vec(), mdl_vec()); end
            idle_tick(10'h0F0);
        end
        checks++; if (nfrq !== 5'd3) begin errors++; $display("FAIL lww_nfrq: got %0d want 3", nfrq); end
        checks++; if (ne !== 1'b1)   begin errors++; $display("FAIL lww_ne: got %b want 1", ne); end
    endtask

    task automatic test_boundary_write();
        adv_to(20, 10'h0AA);
        wr(8'h82, 10'h0AA);
        adv_to(31, 10'h0AA);
        checks++; if (busy !== SYNC) begin errors++; $display("FAIL bnd_busy_before: got %b want %b", busy, SYNC); end
        wr(8'h85, 10'h0AA);
        checks++; if (nfrq !== 5'd5)   begin errors++; $display("FAIL bnd_nfrq: got %0d want 5", nfrq); end
        checks++; if (ne !== 1'b1)     begin errors++; $display("FAIL bnd_ne: got %b want 1", ne); end
        checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL bnd_busy_after: got %b want 0", busy); end
        checks++; if (cycles !== 5'd0) begin errors++; $display("FAIL bnd_cycles: got %0d want 0", cycles); end
    endtask

    task automatic test_eg_latch();
        adv_to(31, 10'h155);
        idle_tick(10'h155);
        checks++; if (noise_eg !== 10'h155) begin errors++; $display("FAIL eg_enabled: got %h want 155", noise_eg); end
        adv_to(4, 10'h155);
        wr(8'h00, 10'h155);
        adv_to(31, 10'h155);
        idle_tick(10'h155);
        checks++; if (ne !== 1'b0) begin errors++; $display("FAIL eg_ne_cleared: got %b want 0", ne); end
        adv_to(31, 10'h155);
        idle_tick(10'h155);
        checks++; if (noise_eg !== 10'h3FF) begin errors++; $display("FAIL eg_silent: got %h want 3ff", noise_eg); end
    endtask

    task automatic test_rst_pend();
        adv_to(8, 10'h011);
        wr(8'h9A, 10'h011);
        adv_to(12, 10'h011);
        tick(1'b1, 1'b1, 8'h00, 8'h00, 10'h011, 1'b1);
        checks++; if (cycles !== 5'd0)      begin errors++; $display("FAIL rstp_cycles: got %0d want 0", cycles); end
        checks++; if (nfrq !== 5'd0)        begin errors++; $display("FAIL rstp_nfrq: got %0d want 0", nfrq); end
        checks++; if (ne !== 1'b0)          begin errors++; $display("FAIL rstp_ne: got %b want 0", ne); end
        checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL rstp_busy: got %b want 0", busy); end
        checks++; if (noise_eg !== 10'h3FF) begin errors++; $display("FAIL rstp_noise_eg: got %h want 3ff", noise_eg); end
        for (int n = 0; n < 40; n++) begin
            idle_tick(10'h011);
            checks++;
            if (nfrq !== 5'd0 || ne !== 1'b0) begin
                errors++; $display("FAIL rstp_not_applied: got ne %b nfrq %0d want 0/0", ne, nfrq);
            end
        end
    endtask

    task automatic test_cen_hold();
        logic [22:0] held;
        adv_to(7, 10'h222);
        wr(8'h8C, 10'h222);
        held = mdl_vec();
        for (int n = 0; n < 10; n++) begin
            tick(1'b0, 1'b0, 8'h0F, 8'($urandom), 10'($urandom), 1'b0);
            checks++;
            if (dut_vec() !== held) begin errors++; $display("FAIL cen_hold: got %h want %h", dut_vec(), held); end
        end
        if (SYNC) begin
            adv_to(0, 10'h222);
            checks++; if (nfrq !== 5'd12) begin errors++; $display("FAIL cen_hold_apply: got %0d want 12", nfrq); end
        end else begin
            wr(8'h07, 10'h222);
            checks++; if (nfrq !== 5'd7) begin errors++; $display("FAIL immediate_write: got %0d want 7", nfrq); end
            checks++; if (ne !== 1'b0)   begin errors++; $display("FAIL immediate_ne: got %b want 0", ne); end
        end
    endtask

    task automatic test_random();
        logic       r, c, w;
        logic [7:0] a;
        for (int n = 0; n < 3000; n++) begin
            r = ($urandom_range(0, 199) == 0);
            c = ($urandom_range(0, 3) != 0);
            w = ($urandom_range(0, 5) != 0);
            a = ($urandom_range(0, 3) != 0) ? 8'h0F : 8'($urandom);
            tick(c, w, a, 8'($urandom), 10'($urandom), r);
            checks++;
            if (dut_vec() !== mdl_vec()) begin errors++; $display("FAIL random_vec step %0d: got %h want %h", n, dut_vec(), mdl_vec()); end
        end
    endtask

    initial begin
        rst = 1'b1; cen = 1'b0; wr_n = 1'b1; addr = 8'h00; din = 8'h00; eg_in = 10'h000;
        m_slot = 0; m_ne = 1'b0; m_nfrq = 5'd0; m_pv = 1'b0; m_pval = 8'h00; m_eg = 10'h3FF;
        @(negedge clk);
        test_reset();
        test_deferred_write();
        test_last_write_wins();
        test_boundary_write();
        test_eg_latch();
        test_rst_pend();
        test_cen_hold();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
